// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, flag indices, FSM states and op predicates
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] ADC = 4'd2;
    localparam logic [3:0] SBB = 4'd3;
    localparam logic [3:0] INC = 4'd4;
    localparam logic [3:0] DEC = 4'd5;
    localparam logic [3:0] SHL = 4'd6;
    localparam logic [3:0] NEG = 4'd7;
    localparam logic [3:0] MOV = 4'd8;
    localparam logic [3:0] NOT = 4'd9;
    localparam logic [3:0] EXP = 4'd10;
    localparam logic [3:0] AND = 4'd11;
    localparam logic [3:0] OR  = 4'd12;
    localparam logic [3:0] XOR = 4'd13;
    localparam logic [3:0] SHR = 4'd14;
    localparam logic [3:0] SAR = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_sub(input logic [3:0] op);
        return (op == SUB) || (op == SBB) || (op == DEC) || (op == NEG);
    endfunction

    function automatic logic is_shr(input logic [3:0] op);
        return (op == SHR) || (op == SAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_if
// Description : Request/response handshake bundle for the serial ALU
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_if #(
    parameter int BYTES = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [8*BYTES-1:0]   a;
    logic [8*BYTES-1:0]   b;
    logic                 carry_in;
    logic                 invert;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*BYTES-1:0]   result;
    logic [3:0]           flags;

    modport master (
        output in_valid, op, a, b, carry_in, invert, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, carry_in, invert, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_byte_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_byte_slice
// Description : Combinational 8-bit ALU step with carry/borrow/shift chaining
// Revision    : 1.0 - initial release
// ============================================================================
module alu_byte_slice
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       chain_in,
    input  logic       first,
    input  logic       last,
    output logic [7:0] r_byte,
    output logic       chain_out
);
    logic [7:0] w_x;
    logic [7:0] w_y;
    logic [8:0] w_sum;
    logic       w_sar_in;

    always_comb begin
        // NEG is 0 - a; INC/DEC inject their 1 only on the first byte
        w_x = (op == NEG) ? 8'h00 : a_byte;
        case (op)
            INC, DEC: w_y = {7'd0, first};
            NEG:      w_y = a_byte;
            default:  w_y = b_byte;
        endcase
        w_sum = is_sub(op) ? ({1'b0, w_x} - {1'b0, w_y} - {8'd0, chain_in})
                           : ({1'b0, w_x} + {1'b0, w_y} + {8'd0, chain_in});
        w_sar_in  = first ? a_byte[7] : chain_in;
        r_byte    = 8'h00;
        chain_out = 1'b0;
        case (op)
            ADD, SUB, ADC, SBB, INC, DEC, NEG: begin
                r_byte    = w_sum[7:0];
                chain_out = w_sum[8];
            end
            SHL: begin
                r_byte    = {a_byte[6:0], chain_in};
                chain_out = a_byte[7];
            end
            SHR: begin
                r_byte    = {chain_in, a_byte[7:1]};
                chain_out = a_byte[0];
            end
            SAR: begin
                r_byte    = {w_sar_in, a_byte[7:1]};
                chain_out = a_byte[0];
            end
            MOV: r_byte = a_byte;
            NOT: r_byte = ~a_byte;
            EXP: begin
                // carry_in rides the chain; it must not leak into the C flag
                r_byte    = {8{chain_in}};
                chain_out = chain_in & ~last;
            end
            AND: r_byte = a_byte & b_byte;
            OR:  r_byte = a_byte | b_byte;
            XOR: r_byte = a_byte ^ b_byte;
            default: r_byte = 8'h00;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial
// Description : Multi-byte ALU processing one byte per clock through one slice
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial
    import alu_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_serial_if.slave bus
);
    localparam int                 c_width    = 8 * BYTES;
    localparam logic [IDX_W-1:0]   c_idx_top  = IDX_W'(BYTES - 1);
    localparam logic [c_width-1:0] c_word_min = {1'b1, {(c_width-1){1'b0}}};

    state_t             r_state;
    logic [3:0]         r_op;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic [c_width-1:0] r_res;
    logic               r_chain;
    logic [IDX_W-1:0]   r_idx;
    logic               r_out_valid;
    logic [3:0]         r_flags;

    logic [7:0]         w_a_byte;
    logic [7:0]         w_b_byte;
    logic [7:0]         w_r_byte;
    logic               w_chain_out;
    logic               w_first;
    logic               w_last;
    logic               w_ovf;
    logic [c_width-1:0] w_res_next;
    logic [3:0]         w_flags_next;

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_res;
    assign bus.flags     = r_flags;

    // Right shifts walk from the top byte down so the shifted-in bit is ready
    assign w_first = is_shr(r_op) ? (r_idx == c_idx_top) : (r_idx == '0);
    assign w_last  = is_shr(r_op) ? (r_idx == '0) : (r_idx == c_idx_top);

    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
            end
        end
    end

    alu_byte_slice u_slice (
        .op        (r_op),
        .a_byte    (w_a_byte),
        .b_byte    (w_b_byte),
        .chain_in  (r_chain),
        .first     (w_first),
        .last      (w_last),
        .r_byte    (w_r_byte),
        .chain_out (w_chain_out)
    );

    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_res_next[8*i +: 8] = w_r_byte;
            end
        end
    end

    // Whole-word flags, sampled on the final byte step
    always_comb begin
        case (r_op)
            ADD, ADC: w_ovf = (r_a[c_width-1] == r_b[c_width-1]) &&
                              (w_res_next[c_width-1] != r_a[c_width-1]);
            SUB, SBB: w_ovf = (r_a[c_width-1] != r_b[c_width-1]) &&
                              (w_res_next[c_width-1] != r_a[c_width-1]);
            INC:      w_ovf = ~r_a[c_width-1] & w_res_next[c_width-1];
            DEC:      w_ovf = r_a[c_width-1] & ~w_res_next[c_width-1];
            NEG:      w_ovf = (r_a == c_word_min);
            default:  w_ovf = 1'b0;
        endcase
        w_flags_next         = 4'd0;
        w_flags_next[FLAG_O] = w_ovf;
        w_flags_next[FLAG_S] = w_res_next[c_width-1];
        w_flags_next[FLAG_C] = w_chain_out;
        w_flags_next[FLAG_Z] = (w_res_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_chain     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_flags     <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= bus.op;
                        r_a     <= bus.invert ? bus.b : bus.a;
                        r_b     <= bus.invert ? bus.a : bus.b;
                        r_chain <= (bus.op == ADC || bus.op == SBB || bus.op == EXP) ?
                                   bus.carry_in : 1'b0;
                        r_idx   <= is_shr(bus.op) ? c_idx_top : '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_chain <= w_chain_out;
                    if (w_last) begin
                        r_flags     <= w_flags_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= is_shr(r_op) ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
